reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32-entry integer register file and gates instruction issue from decode.
- An instruction issues only when none of the registers it uses has a pending write.
- On issue, the scoreboard marks the destination busy; a writeback-port event clears it.
- Sits between decode and execute. Drives the pipeline stall and exports debug and performance state.

Parameters:
- MAX_OUTSTANDING, 4, maximum tracked in-flight register writes (1..31).
- CNT_W, 5, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.
- WB_BYPASS, 0, 1 = a register cleared by writeback in the current cycle counts as not busy for same-cycle issue checks.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1  input  5  source 1 index.
- issue_rs1_used  input  1  instruction reads rs1.
- issue_rs2  input  5  source 2 index.
- issue_rs2_used  input  1  instruction reads rs2.
- issue_rd  input  5  destination index.
- issue_rd_we  input  1  instruction writes rd.
- issue_ready  output  1  instruction may issue this cycle; combinational.
- wb_valid  input  1  register-file write occurs this cycle.
- wb_rd  input  5  register written.
- flush  input  1  discard all pending tracking.
- busy_mask  output  32  registered busy bit per register; bit 0 always 0.
- outstanding  output  CNT_W  number of busy registers.
- stall_count  output  32  cycles with issue_valid=1 and issue_ready=0; saturating.
- err_spurious_wb  output  1  sticky: writeback to a register that was not busy.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: busy_mask=0, outstanding=0, stall_count=0, err_spurious_wb=0. Reset overrides flush, issue and writeback in the same cycle.
- Effective busy: eb = busy_mask, except when WB_BYPASS=1 and wb_valid, wb_rd!=0, in which case bit wb_rd is cleared in eb.
- Hazards (all evaluated on eb):
  - RAW: issue_rs1_used and eb[rs1], or issue_rs2_used and eb[rs2].
  - WAW: issue_rd_we and rd!=0 and eb[rd].
  - Full: issue_rd_we and rd!=0 and outstanding==MAX_OUTSTANDING, and no same-cycle valid writeback to a busy register that would free a slot.
- issue_ready = !flush and no RAW, WAW or Full hazard. Independent of issue_valid; no combinational path from issue_valid.
- Fire: issue_valid and issue_ready. On fire with issue_rd_we and rd!=0, busy[rd] is set at the next edge.
- Register x0 is never tracked: an issue with rd=0 sets nothing, and writeback with wb_rd=0 is ignored with no error.
- Writeback with wb_rd!=0:
  - If busy[wb_rd]=1, the bit clears next edge.
  - If busy[wb_rd]=0, the bit is unchanged and err_spurious_wb is set (sticky until reset).
- Simultaneous writeback and issue on the same rd: legal only under WB_BYPASS=1 (otherwise WAW blocks the issue). The clear applies first and the set second, so the bit ends at 1 and outstanding is unchanged.
- Counter update: outstanding_next = outstanding + set - clear. It must always equal popcount(busy_mask).
- stall_count: increments when issue_valid and !issue_ready (flush cycles included); holds at 0xFFFFFFFF.
- Flush:
  - busy_mask and outstanding go to 0 at the next edge.
  - issue_ready=0 during the flush cycle.
  - Writeback in the flush cycle is ignored, with no error.
  - stall_count and err_spurious_wb are preserved.
- Latency: busy state is visible on busy_mask one cycle after the fire or writeback edge.

Test Plan:
- Reset, then idle: issue rs1=3, rs2=4, rd=5 -> issue_ready=1; next cycle busy_mask=0x00000020, outstanding=1.
- RAW stall: with x5 busy, issue rs1=5 held valid for 3 cycles -> issue_ready=0 and stall_count=3. wb_rd=5 then clears busy; issue_ready=1 the next cycle (WB_BYPASS=0), and in the same cycle as the writeback when WB_BYPASS=1.
- Capacity: issue rd=1,2,3,4 back-to-back (MAX_OUTSTANDING=4) -> outstanding=4; issue rd=6 -> ready=0. Issue rd=6 in the same cycle as wb_rd=2 -> ready=1; outstanding stays 4 and busy_mask=0x0000005A.
- x0 handling: issue rd=0 with rd_we -> busy_mask stays 0, outstanding 0; wb_rd=0 -> err_spurious_wb stays 0.
- Spurious writeback: wb_rd=9 with x9 not busy -> err_spurious_wb=1 next cycle and stays 1 after later valid traffic until rst.
- Flush and reset: with x1..x3 busy, assert flush plus issue plus wb_rd=1 -> no fire; next cycle busy_mask=0, outstanding=0, err unchanged. Asserting rst mid-stall -> all outputs return to 0 next cycle.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes to x1..x31 and gates issue.
// Exports busy state, outstanding count, stall count and a spurious-wb flag.
module reg_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 5,
  parameter bit WB_BYPASS       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic             issue_rs1_used,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_rs2_used,
  input  logic [4:0]       issue_rd,
  input  logic             issue_rd_we,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] outstanding,
  output logic [31:0]      stall_count,
  output logic             err_spurious_wb
);

  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_stall;
  logic             r_err;

  logic [31:0] w_wb_oh;
  logic [31:0] w_rd_oh;
  logic [31:0] w_eb;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic        w_wb_hit;
  logic        w_rd_act;
  logic        w_raw;
  logic        w_waw;
  logic        w_full;
  logic        w_fire;
  logic        w_spur;
  logic        w_stall;

  assign w_wb_oh = (wb_valid && wb_rd != 5'd0)
                 ? (32'd1 << wb_rd) : 32'd0;
  assign w_rd_act = issue_rd_we && issue_rd != 5'd0;
  assign w_rd_oh  = w_rd_act ? (32'd1 << issue_rd) : 32'd0;

  // Bypass lets a same-cycle writeback release its register early
  assign w_eb = WB_BYPASS ? (r_busy & ~w_wb_oh) : r_busy;

  assign w_wb_hit = |(w_wb_oh & r_busy);

  assign w_raw = (issue_rs1_used && w_eb[issue_rs1])
              || (issue_rs2_used && w_eb[issue_rs2]);
  assign w_waw = w_rd_act && w_eb[issue_rd];
  assign w_full = w_rd_act
               && (r_cnt == CNT_W'(MAX_OUTSTANDING))
               && !w_wb_hit;

  assign issue_ready = !flush && !w_raw && !w_waw && !w_full;

  assign w_fire  = issue_valid && issue_ready;
  assign w_set   = w_fire ? w_rd_oh : 32'd0;
  assign w_clr   = flush ? 32'd0 : (w_wb_oh & r_busy);
  assign w_spur  = !flush && (|w_wb_oh) && !w_wb_hit;
  assign w_stall = issue_valid && !issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 32'd0;
      r_cnt   <= '0;
      r_stall <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (flush) begin
        r_busy <= 32'd0;
        r_cnt  <= '0;
      end else begin
        // Clear before set so a same-rd wb+issue leaves the bit busy
        r_busy <= (r_busy & ~w_clr) | w_set;
        r_cnt  <= r_cnt + CNT_W'(|w_set) - CNT_W'(|w_clr);
      end
      if (w_stall && r_stall != 32'hFFFF_FFFF)
        r_stall <= r_stall + 32'd1;
      if (w_spur)
        r_err <= 1'b1;
    end
  end

  assign busy_mask       = r_busy;
  assign outstanding     = r_cnt;
  assign stall_count     = r_stall;
  assign err_spurious_wb = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed cases plus random traffic on two
// instances (no bypass / bypass) against an array-based reference model.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst;
  logic       iv;
  logic [4:0] rs1, rs2, rd, wbr;
  logic       rs1u, rs2u, rdwe, wbv, fl;

  logic        rdy0, rdy1, err0, err1;
  logic [31:0] bm0, bm1, sc0, sc1;
  logic [4:0]  out0, out1;

  int n_chk = 0;
  int n_err = 0;

  bit     m_busy [2][32];
  longint m_stall[2];
  bit     m_err  [2];

  reg_scoreboard #(.WB_BYPASS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .issue_valid(iv),
    .issue_rs1(rs1), .issue_rs1_used(rs1u),
    .issue_rs2(rs2), .issue_rs2_used(rs2u),
    .issue_rd(rd), .issue_rd_we(rdwe),
    .issue_ready(rdy0), .wb_valid(wbv), .wb_rd(wbr),
    .flush(fl), .busy_mask(bm0), .outstanding(out0),
    .stall_count(sc0), .err_spurious_wb(err0)
  );

  reg_scoreboard #(.WB_BYPASS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .issue_valid(iv),
    .issue_rs1(rs1), .issue_rs1_used(rs1u),
    .issue_rs2(rs2), .issue_rs2_used(rs2u),
    .issue_rd(rd), .issue_rd_we(rdwe),
    .issue_ready(rdy1), .wb_valid(wbv), .wb_rd(wbr),
    .flush(fl), .busy_mask(bm1), .outstanding(out1),
    .stall_count(sc1), .err_spurious_wb(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_eb(int b, int r);
    bool_bypass: begin end
    return m_busy[b][r]
        && !(b == 1 && wbv && int'(wbr) == r && r != 0);
  endfunction

  function automatic int m_cnt(int b);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[b][i]);
    return c;
  endfunction

  function automatic logic [31:0] m_mask(int b);
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = m_busy[b][i];
    return m;
  endfunction

  function automatic bit m_ready(int b);
    bit frees, haz;
    frees = wbv && wbr != 0 && m_busy[b][wbr];
    haz = (rs1u && m_eb(b, int'(rs1)))
       || (rs2u && m_eb(b, int'(rs2)));
    if (rdwe && rd != 0) begin
      if (m_eb(b, int'(rd))) haz = 1;
      if (m_cnt(b) == 4 && !frees) haz = 1;
    end
    return !fl && !haz;
  endfunction

  task automatic m_update();
    for (int b = 0; b < 2; b++) begin
      bit rdy = m_ready(b);
      if (rst) begin
        for (int i = 0; i < 32; i++) m_busy[b][i] = 0;
        m_stall[b] = 0;
        m_err[b]   = 0;
      end else begin
        if (iv && !rdy && m_stall[b] < 64'hFFFF_FFFF)
          m_stall[b]++;
        if (fl) begin
          for (int i = 0; i < 32; i++) m_busy[b][i] = 0;
        end else begin
          if (wbv && wbr != 0) begin
            if (m_busy[b][wbr]) m_busy[b][wbr] = 0;
            else m_err[b] = 1;
          end
          if (iv && rdy && rdwe && rd != 0)
            m_busy[b][rd] = 1;
        end
      end
    end
  endtask

  task automatic apply(input bit v,
                       input int a, input bit au,
                       input int c, input bit cu,
                       input int d, input bit dw,
                       input bit wv, input int wr,
                       input bit f);
    iv = v;
    rs1 = 5'(a); rs1u = au;
    rs2 = 5'(c); rs2u = cu;
    rd = 5'(d); rdwe = dw;
    wbv = wv; wbr = 5'(wr);
    fl = f;
    #1;
  endtask

  task automatic tick();
    chk("rdy0", 64'(rdy0), 64'(m_ready(0)));
    chk("rdy1", 64'(rdy1), 64'(m_ready(1)));
    @(posedge clk);
    m_update();
    #1;
    chk("bm0", 64'(bm0), 64'(m_mask(0)));
    chk("bm1", 64'(bm1), 64'(m_mask(1)));
    chk("out0", 64'(out0), 64'(m_cnt(0)));
    chk("out1", 64'(out1), 64'(m_cnt(1)));
    chk("sc0", 64'(sc0), 64'(m_stall[0]));
    chk("sc1", 64'(sc1), 64'(m_stall[1]));
    chk("err0", 64'(err0), 64'(m_err[0]));
    chk("err1", 64'(err1), 64'(m_err[1]));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bm", 64'(bm0), 64'd0);
    chk("rst_out", 64'(out0), 64'd0);
    chk("rst_sc", 64'(sc0), 64'd0);
    chk("rst_err", 64'(err1), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    apply(1, 3, 1, 4, 1, 5, 1, 0, 0, 0);
    chk("idle_rdy", 64'(rdy0), 64'd1);
    tick();
    chk("idle_bm", 64'(bm0), 64'h20);
    chk("idle_out", 64'(out0), 64'd1);

    for (int i = 0; i < 3; i++) begin
      apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("raw_rdy", 64'(rdy0), 64'd0);
      tick();
    end
    chk("raw_sc", 64'(sc0), 64'd3);

    apply(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    chk("wb_rdy0", 64'(rdy0), 64'd0);
    chk("wb_rdy1", 64'(rdy1), 64'd1);
    tick();
    chk("wb_sc0", 64'(sc0), 64'd4);
    chk("wb_sc1", 64'(sc1), 64'd3);
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rdy0", 64'(rdy0), 64'd1);
    tick();

    for (int d = 1; d <= 4; d++) begin
      apply(1, 0, 0, 0, 0, d, 1, 0, 0, 0);
      tick();
    end
    chk("cap_out", 64'(out0), 64'd4);
    apply(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    chk("full_rdy", 64'(rdy0), 64'd0);
    tick();
    apply(1, 0, 0, 0, 0, 6, 1, 1, 2, 0);
    chk("free_rdy", 64'(rdy0), 64'd1);
    tick();
    chk("free_out", 64'(out0), 64'd4);
    chk("free_bm", 64'(bm0), 64'h5A);

    apply(1, 0, 0, 0, 0, 7, 1, 1, 1, 1);
    chk("fl_rdy", 64'(rdy0), 64'd0);
    tick();
    chk("fl_bm", 64'(bm0), 64'd0);
    chk("fl_out", 64'(out0), 64'd0);
    chk("fl_err", 64'(err0), 64'd0);

    apply(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    chk("x0_bm", 64'(bm0), 64'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk("x0_err", 64'(err0), 64'd0);

    apply(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    chk("spur_err", 64'(err0), 64'd1);
    apply(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    chk("sticky", 64'(err0), 64'd1);

    apply(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    apply(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("mrst_bm", 64'(bm0), 64'd0);
    chk("mrst_sc", 64'(sc0), 64'd0);
    chk("mrst_err", 64'(err0), 64'd0);
    chk("mrst_out", 64'(out0), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom % 200) == 0;
      apply(($urandom % 4) != 0,
            int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), ($urandom % 4) != 0,
            1'($urandom), int'($urandom_range(0, 7)),
            ($urandom % 50) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
